// File: rtl/dbus_pkg.sv
// Shared types for the data-bus Wishbone bridge: funct3 access encodings and FSM states.
package dbus_pkg;

    typedef enum logic [2:0] {
        MEM_OP_B  = 3'b000,
        MEM_OP_H  = 3'b001,
        MEM_OP_W  = 3'b010,
        MEM_OP_BU = 3'b100,
        MEM_OP_HU = 3'b101
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } dbus_state_t;

    localparam int TMO_CNT_MIN_W = 8;

    // Halfwords need an even address, words a 4-byte aligned one; anything
    // not decoded as B/H is sized as a word.
    function automatic logic access_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        logic mis;
        case (mem_op_t'(op))
            MEM_OP_B, MEM_OP_BU: mis = 1'b0;
            MEM_OP_H, MEM_OP_HU: mis = addr_lo[0];
            default:             mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dbus_lane_align.sv
// Byte-lane steering: store replication/select, load lane extract + extension, alignment check.
// Purely combinational; no latency, no flow control of its own.
// Backpressure: none, the bridge FSM decides when outputs are used.
module dbus_lane_align
    import dbus_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [2:0]  ld_op,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] bus_rdata,
    output logic [31:0] st_dat,
    output logic [3:0]  st_sel,
    output logic [31:0] ld_dat,
    output logic        misaligned
);

    logic [31:0] ld_shifted;

    always_comb begin
        st_dat     = wdata;
        st_sel     = 4'b1111;
        misaligned = access_misaligned(op, addr_lo);
        case (mem_op_t'(op))
            MEM_OP_B, MEM_OP_BU: begin
                st_dat = {4{wdata[7:0]}};
                st_sel = 4'b0001 << addr_lo;
            end
            MEM_OP_H, MEM_OP_HU: begin
                st_dat = {2{wdata[15:0]}};
                st_sel = 4'b0011 << addr_lo;
            end
            default: ;
        endcase
    end

    assign ld_shifted = bus_rdata >> {ld_addr_lo, 3'b000};

    always_comb begin
        ld_dat = ld_shifted;
        case (mem_op_t'(ld_op))
            MEM_OP_B:  ld_dat = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            MEM_OP_BU: ld_dat = {24'h0, ld_shifted[7:0]};
            MEM_OP_H:  ld_dat = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            MEM_OP_HU: ld_dat = {16'h0, ld_shifted[15:0]};
            default:   ld_dat = ld_shifted;
        endcase
    end

endmodule

// File: rtl/core_dbus_wb_bridge.sv
// MEM-stage load/store to one Wishbone classic transfer; optional DBUS_TIMEOUT_EN bus watchdog.
// Latency: 3 cycles per aligned access with immediate ack (+1 per wait state), 2 when misaligned.
// Backpressure: stall_pipl holds the pipeline from request until the DONE cycle.
module core_dbus_wb_bridge
    import dbus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr_mem,
    input  logic [31:0] mem_wdata_mem,
    input  logic        mem_write_mem,
    input  logic        mem_read_mem,
    input  logic [2:0]  mem_op_mem,
    output logic [31:0] mem_rdata_mem,
    output logic        stall_pipl,
    output logic        bus_err,
    output logic        misaligned,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    dbus_state_t state_q, state_nxt;

    logic        req;
    logic        mis_det;
    logic        bus_start;
    logic        mis_start;
    logic        bus_fail;
    logic        timeout_hit;
    logic [31:0] st_dat;
    logic [3:0]  st_sel;
    logic [31:0] ld_dat;
    logic [2:0]  ld_op_q;
    logic [1:0]  ld_addr_q;

    assign req = mem_read_mem | mem_write_mem;

    dbus_lane_align u_lane_align (
        .op         (mem_op_mem),
        .addr_lo    (mem_addr_mem[1:0]),
        .wdata      (mem_wdata_mem),
        .ld_op      (ld_op_q),
        .ld_addr_lo (ld_addr_q),
        .bus_rdata  (wb_dat_i),
        .st_dat     (st_dat),
        .st_sel     (st_sel),
        .ld_dat     (ld_dat),
        .misaligned (mis_det)
    );

`ifdef DBUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > TMO_CNT_MIN_W) ?
                           $clog2(TIMEOUT_CYCLES + 1) : TMO_CNT_MIN_W;

    logic [CNT_W-1:0] tmo_cnt;

    // Counts completed BUS cycles; zero in the first BUS cycle.
    always_ff @(posedge clk) begin
        if (reset || state_q != ST_BUS) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (state_q == ST_BUS) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the watchdog the limit is meaningless; BUS waits for the slave forever.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    assign bus_start = (state_q == ST_IDLE) && req && !mis_det;
    assign mis_start = (state_q == ST_IDLE) && req && mis_det;
    // Error beats ack; a timeout only counts when the slave stayed silent.
    assign bus_fail  = (state_q == ST_BUS) && (wb_err_i || (timeout_hit && !wb_ack_i));

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = mis_det ? ST_DONE : ST_BUS;
                end
            end
            ST_BUS: begin
                if (wb_ack_i || wb_err_i || timeout_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_we_o       <= 1'b0;
            wb_sel_o      <= 4'b0000;
            wb_adr_o      <= 32'h0;
            wb_dat_o      <= 32'h0;
            ld_op_q       <= 3'b000;
            ld_addr_q     <= 2'b00;
            mem_rdata_mem <= 32'h0;
            bus_err       <= 1'b0;
            misaligned    <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            wb_cyc_o   <= (state_nxt == ST_BUS);
            wb_stb_o   <= (state_nxt == ST_BUS);
            bus_err    <= bus_fail;
            misaligned <= mis_start;
            if (bus_start) begin
                wb_adr_o  <= {mem_addr_mem[31:2], 2'b00};
                wb_dat_o  <= st_dat;
                wb_sel_o  <= st_sel;
                wb_we_o   <= mem_write_mem;
                ld_op_q   <= mem_op_mem;
                ld_addr_q <= mem_addr_mem[1:0];
            end
            if (mis_start || bus_fail) begin
                mem_rdata_mem <= 32'h0;
            end else if (state_q == ST_BUS && wb_ack_i && !wb_we_o) begin
                mem_rdata_mem <= ld_dat;
            end
        end
    end

    assign stall_pipl = !reset && (((state_q == ST_IDLE) && req) || (state_q == ST_BUS));

endmodule

// File: doc/core_dbus_wb_bridge.md
# core_dbus_wb_bridge

Responder side of the core's data-memory bus: accepts the MEM-stage load/store request (`mem_addr_mem`, `mem_wdata_mem`, `mem_write_mem`, `mem_read_mem`, `mem_op_mem`) and turns it into one Wishbone classic single transfer. It returns sized, sign- or zero-extended load data on `mem_rdata_mem`. It holds the pipeline via `stall_pipl` until the transfer completes, and sits between the core top and the SoC Wishbone interconnect.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus cycles allowed before forced error termination (used only with `DBUS_TIMEOUT_EN`).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `mem_addr_mem` in 32: byte address.
- `mem_wdata_mem` in 32: store data in the low lanes.
- `mem_write_mem` in 1: store request.
- `mem_read_mem` in 1: load request.
- `mem_op_mem` in 3: funct3. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `mem_rdata_mem` out 32: extended load data.
- `stall_pipl` out 1: freeze pipeline.
- `bus_err` out 1: one-cycle pulse on error termination.
- `misaligned` out 1: one-cycle pulse on a misaligned access.
- `wb_adr_o` out 32, `wb_dat_o` out 32, `wb_sel_o` out 4, `wb_we_o` out 1, `wb_cyc_o` out 1, `wb_stb_o` out 1: Wishbone master outputs.
- `wb_dat_i` in 32, `wb_ack_i` in 1, `wb_err_i` in 1: Wishbone slave responses.

## Operation
- **Request.** req = `mem_read_mem | mem_write_mem`. If both are high, the request is a store.
- **Alignment.** H/HU needs `addr[0]==0`. W needs `addr[1:0]==0`.
  - A misaligned request issues no bus cycle.
  - The FSM goes straight to DONE with `misaligned`=1.
  - `mem_rdata_mem` becomes 0.
- **FSM states:**
  - IDLE: an aligned req moves to BUS. A misaligned req moves to DONE.
  - BUS: `wb_ack_i` or `wb_err_i` moves to DONE. `wb_err_i` wins if both are high.
  - DONE: unconditionally moves to IDLE.
- **Bus drive.** `wb_cyc_o`/`wb_stb_o` are registered and high for exactly the BUS cycles. `wb_adr_o` = {addr[31:2],2'b00}. `wb_adr_o`, `wb_dat_o`, `wb_sel_o` and `wb_we_o` are latched on IDLE→BUS and held stable through BUS.
- **Store lanes:**
  - B: data = {4{wdata[7:0]}}, sel = 4'b0001<<addr[1:0].
  - H: data = {2{wdata[15:0]}}, sel = 4'b0011<<addr[1:0].
  - W: data = wdata, sel = 4'b1111.
- **Load extraction.** Select the lane by `addr[1:0]` from `wb_dat_i`. Sign-extend for B/H; zero-extend for BU/HU. The result is registered into `mem_rdata_mem` on ack.
  - On error or misalignment the register loads 0.
  - Otherwise `mem_rdata_mem` holds its last value.
- **stall_pipl** (combinational) = !reset & ((IDLE & req) | BUS). It is 0 in DONE, so the pipeline advances exactly once per completed access. The same request is never re-issued.
- **Status pulses.** `bus_err` and `misaligned` are registered and high only during DONE.

## Timing
- **Reset values:** state IDLE; `wb_cyc_o`, `wb_stb_o`, `wb_we_o` = 0; `wb_sel_o` = 0; `wb_adr_o`, `wb_dat_o` = 0; `mem_rdata_mem` = 0; `bus_err`, `misaligned` = 0; `stall_pipl` = 0 while reset is high.
- **Load latency** with same-cycle ack (ack in first BUS cycle):
  - Cycle 0: IDLE, stall=1.
  - Cycle 1: BUS, stall=1.
  - Cycle 2: DONE, data valid, stall=0.
  - Each wait state adds one cycle.
- **Misaligned access:** one stall cycle, then DONE.
- **Back-to-back requests:** IDLE→BUS for the next request starts the cycle after DONE. Minimum 3 cycles per access.
- **Reset mid-BUS:** `cyc`/`stb` drop at the next edge. Late acks are ignored in IDLE.
- **Spurious ack/err outside BUS:** ignored.

## Configuration
- `DBUS_TIMEOUT_EN` defined:
  - An 8+ bit counter clears on entry to BUS and increments each BUS cycle.
  - When it reaches `TIMEOUT_CYCLES` with no ack/err, the bridge terminates the transfer as an error: DONE, `bus_err`=1, rdata 0.
- Undefined: no counter. BUS waits indefinitely for ack/err.

## Structure
- **Package `dbus_pkg`:** `mem_op_t` enum (funct3 encodings above) and `dbus_state_t` enum (IDLE, BUS, DONE).
- **Sub-module `dbus_lane_align`** (combinational): store data replication and `sel` generation, load lane extraction and extension, misalignment detect.
- **Top:** FSM, registers and timeout.

## Test plan
- LW addr 0x100, ack in first BUS cycle, `wb_dat_i`=0xDEADBEEF → `wb_sel_o`=1111, `mem_rdata_mem`=0xDEADBEEF in cycle 2, `stall_pipl` pattern 1,1,0.
- LB addr 0x103, `wb_dat_i`=0x80112233 → rdata 0xFFFFFF80. LBU same → 0x00000080. LHU addr 0x102 → 0x00008011.
- SB addr 0x201, wdata 0x000000A5 → `wb_adr_o`=0x200, `wb_dat_o`=0xA5A5A5A5, `wb_sel_o`=0010, `wb_we_o`=1. SH addr 0x202 → `wb_sel_o`=1100.
- LW addr 0x102 → no `wb_cyc_o`, `misaligned` pulse, rdata 0, stall 1 then 0.
- Slave asserts `wb_err_i` after 3 wait states → `bus_err` one cycle, rdata 0. With `DBUS_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4 and a silent slave → `bus_err` pulses after 4 BUS cycles.
- Reset asserted in the second BUS cycle → next edge: `cyc`/`stb`=0, stall=0, state IDLE. A following LW completes normally.
